// File: rtl/cache_miss_sequencer.sv
// cache_miss_sequencer: miss-handling controller for the direct-mapped line cache.
// Evicts a valid victim line to SDRAM, fetches the missing line through the SDRAM
// controller's read FIFO, refills the line buffer and commits it in one cycle.
// The critical byte of a load miss is delivered as soon as its word is popped.
module cache_miss_sequencer #(
   parameter int OFFSETWIDTH = 5,
   parameter int INDEXWIDTH  = 11
) (
   input  logic                                clock,
   input  logic                                reset_n,
   // cache hit logic
   input  logic                                miss,
   input  logic                                miss_load,
   input  logic [23:0]                         miss_addr,
   input  logic                                victim_valid,
   input  logic [23-INDEXWIDTH-OFFSETWIDTH:0]  victim_tag,
   input  logic [15:0]                         victim_word,
   output logic [OFFSETWIDTH-2:0]              victim_waddr,
   // cache array refill
   output logic                                fill_we,
   output logic [OFFSETWIDTH-2:0]              fill_waddr,
   output logic [15:0]                         fill_word,
   output logic                                commit,
   // processor side
   output logic                                busy,
   output logic [7:0]                          d_out,
   output logic                                new_dout,
   // SDRAM controller request lines
   output logic [23:0]                         ram_addr,
   output logic                                readreq,
   output logic                                writereq,
   input  logic                                req_ready,
   // SDRAM controller write FIFO
   output logic [15:0]                         data_to_ram,
   output logic                                write,
   input  logic                                writeready,
   // SDRAM controller read FIFO (show-ahead)
   input  logic [15:0]                         data_from_ram,
   output logic                                read,
   input  logic                                readready
);

   localparam int TAGWIDTH = 24 - INDEXWIDTH - OFFSETWIDTH;
   localparam int WORDS    = (2 ** OFFSETWIDTH) / 2;
   localparam int WCNT     = $clog2(WORDS);
   localparam logic [WCNT-1:0] LAST = WCNT'(WORDS - 1);

   typedef enum logic [2:0] {
      IDLE,
      READREQ,
      WRITEREQ,
      EVICT,
      FILL,
      COMMIT
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [WCNT-1:0]         cnt;
   logic [INDEXWIDTH-1:0]   miss_index;
   logic [OFFSETWIDTH-1:0]  miss_offset;
   logic                    load_q;
   logic                    vvalid_q;
   logic [TAGWIDTH-1:0]     vtag_q;
   logic                    accept;

   // A new miss is only taken while idle; misses seen while busy are ignored.
   assign accept = (state == IDLE) && miss;

   // State register.
   // NOTE: reset is synchronous here, so it lives inside the clocked branch rather than the sensitivity list.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode plus the FIFO strobes, which react to ready in the same cycle.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_next = state;
      write      = 1'b0;
      read       = 1'b0;
      fill_we    = 1'b0;
      commit     = 1'b0;
      case (state)
         IDLE: begin
            if (miss) state_next = READREQ;
         end
         READREQ: begin
            if (req_ready) state_next = vvalid_q ? WRITEREQ : FILL;
         end
         WRITEREQ: begin
            if (req_ready) state_next = EVICT;
         end
         EVICT: begin
            write = writeready;
            if (writeready && (cnt == LAST)) state_next = FILL;
         end
         FILL: begin
            read    = readready;
            fill_we = readready;
            if (readready && (cnt == LAST)) state_next = COMMIT;
         end
         COMMIT: begin
            commit     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy         = (state != IDLE);
   assign victim_waddr = cnt;
   assign fill_waddr   = cnt;
   assign fill_word    = data_from_ram;
   assign data_to_ram  = victim_word;

   // Capture the miss context when the miss is accepted; it must survive the whole sequence.
   always_ff @(posedge clock) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n) begin
         miss_index  <= '0;
         miss_offset <= '0;
         load_q      <= 1'b0;
         vvalid_q    <= 1'b0;
         vtag_q      <= '0;
      end else if (accept) begin
         miss_index  <= miss_addr[23:24-INDEXWIDTH];
         miss_offset <= miss_addr[OFFSETWIDTH-1:0];
         load_q      <= miss_load;
         vvalid_q    <= victim_valid;
         vtag_q      <= victim_tag;
      end
   end

   // Word counter shared by eviction and fill; wraps to zero on the last word of each.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (write || read) begin
         cnt <= cnt + WCNT'(1);
      end
   end

   // Registered request lines: each is high exactly while its request state is pending.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         readreq  <= 1'b0;
         writereq <= 1'b0;
         ram_addr <= '0;
      end else begin
         readreq  <= (state_next == READREQ);
         writereq <= (state_next == WRITEREQ);
         if (accept) begin
            ram_addr <= {miss_addr[23:OFFSETWIDTH], {OFFSETWIDTH{1'b0}}};
         end else if ((state == READREQ) && req_ready && vvalid_q) begin
            ram_addr <= {miss_index, vtag_q, {OFFSETWIDTH{1'b0}}};
         end
      end
   end

   // Critical-byte capture: grab the addressed byte on the pop of its word, strobe next cycle.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         d_out    <= '0;
         new_dout <= 1'b0;
      end else begin
         new_dout <= 1'b0;
         if (read && load_q && (cnt == miss_offset[OFFSETWIDTH-1:1])) begin
            d_out    <= miss_offset[0] ? data_from_ram[15:8] : data_from_ram[7:0];
            new_dout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// tb_cache_miss_sequencer: table-driven bench for the cache miss sequencer.
// A small SDRAM-side model feeds the read FIFO and accepts requests; expected
// eviction words, fill words and critical bytes are queued when a miss is driven
// and popped as the DUT produces them.
module tb_cache_miss_sequencer;

   typedef struct {
      logic [23:0] addr;
      logic        load;
      logic        vvalid;
      logic [7:0]  vtag;
      logic        toggle;    // readready alternates during the fill
      logic        stall;     // writeready dropped for 10 cycles mid-eviction
      logic        hold;      // miss held high through the whole sequence
      logic [23:0] exp_rd;    // expected ram_addr with readreq
      logic [23:0] exp_wr;    // expected ram_addr with writereq
      logic        exp_dv;    // a critical byte is expected
      logic [7:0]  exp_dout;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        miss = 1'b0;
   logic        miss_load = 1'b0;
   logic [23:0] miss_addr = '0;
   logic        victim_valid = 1'b0;
   logic [7:0]  victim_tag = '0;
   logic [15:0] victim_word;
   logic [3:0]  victim_waddr;
   logic        fill_we;
   logic [3:0]  fill_waddr;
   logic [15:0] fill_word;
   logic        commit;
   logic        busy;
   logic [7:0]  d_out;
   logic        new_dout;
   logic [23:0] ram_addr;
   logic        readreq;
   logic        writereq;
   logic        req_ready = 1'b0;
   logic [15:0] data_to_ram;
   logic        write;
   logic        writeready = 1'b1;
   logic [15:0] data_from_ram = '0;
   logic        read;
   logic        readready = 1'b0;

   int          checks = 0;
   int          errors = 0;
   int          commit_cnt = 0;
   int          readreq_cnt = 0;
   logic        readreq_prev = 1'b0;
   logic        pop_pending = 1'b0;
   logic        rd_toggle = 1'b0;
   logic        rd_phase = 1'b0;
   logic [19:0] mon_e;

   logic [19:0] fill_q[$];
   logic [19:0] evict_q[$];
   logic [7:0]  dout_q[$];
   logic [15:0] rd_fifo[$];

   vec_t        tbl[5];

   always #5 clock = ~clock;

   cache_miss_sequencer dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .miss          (miss),
      .miss_load     (miss_load),
      .miss_addr     (miss_addr),
      .victim_valid  (victim_valid),
      .victim_tag    (victim_tag),
      .victim_word   (victim_word),
      .victim_waddr  (victim_waddr),
      .fill_we       (fill_we),
      .fill_waddr    (fill_waddr),
      .fill_word     (fill_word),
      .commit        (commit),
      .busy          (busy),
      .d_out         (d_out),
      .new_dout      (new_dout),
      .ram_addr      (ram_addr),
      .readreq       (readreq),
      .writereq      (writereq),
      .req_ready     (req_ready),
      .data_to_ram   (data_to_ram),
      .write         (write),
      .writeready    (writeready),
      .data_from_ram (data_from_ram),
      .read          (read),
      .readready     (readready)
   );

   function automatic logic [15:0] fill_pat(input logic [3:0] i);
      return {4'hB, i, 4'h5, i};
   endfunction

   function automatic logic [15:0] victim_pat(input logic [3:0] i);
      return {4'hE, i, 4'h7, ~i};
   endfunction

   // Cache array model: combinational read of the victim line.
   assign victim_word = victim_pat(victim_waddr);

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Read FIFO model: retire the word popped at the last edge, then present the next one.
   always @(negedge clock) begin
      if (pop_pending) begin
         if (rd_fifo.size() > 0) rd_fifo.delete(0);
         pop_pending = 1'b0;
      end
      rd_phase      = ~rd_phase;
      readready     = (rd_fifo.size() > 0) && (!rd_toggle || rd_phase);
      data_from_ram = (rd_fifo.size() > 0) ? rd_fifo[0] : 16'h0000;
   end

   // Output monitor, sampled mid low phase after all drivers have settled.
   always begin
      @(negedge clock);
      #2;
      if (write) begin
         if (evict_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL evict_extra: unexpected push at victim_waddr=%0d", victim_waddr);
         end else begin
            mon_e = evict_q.pop_front();
            check("evict_waddr", 32'(victim_waddr), 32'(mon_e[19:16]));
            check("evict_data", 32'(data_to_ram), 32'(mon_e[15:0]));
         end
      end
      if (fill_we) begin
         pop_pending = 1'b1;
         check("fill_read_strobe", 32'(read), 32'd1);
         if (fill_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL fill_extra: unexpected fill at fill_waddr=%0d", fill_waddr);
         end else begin
            mon_e = fill_q.pop_front();
            check("fill_waddr", 32'(fill_waddr), 32'(mon_e[19:16]));
            check("fill_word", 32'(fill_word), 32'(mon_e[15:0]));
         end
      end
      if (new_dout) begin
         if (dout_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL dout_extra: unexpected new_dout with d_out=%0h", d_out);
         end else begin
            check("d_out", 32'(d_out), 32'(dout_q.pop_front()));
         end
      end
      if (commit) commit_cnt++;
      if (readreq && !readreq_prev) readreq_cnt++;
      readreq_prev = readreq;
   end

   task automatic run_vec(input int idx, input vec_t v);
      int c0;
      int r0;
      int cyc;
      bit ok;
      c0 = commit_cnt;
      r0 = readreq_cnt;
      @(negedge clock);
      miss         = 1'b1;
      miss_load    = v.load;
      miss_addr    = v.addr;
      victim_valid = v.vvalid;
      victim_tag   = v.vtag;
      rd_toggle    = v.toggle;
      for (int i = 0; i < 16; i++) begin
         fill_q.push_back({4'(i), fill_pat(4'(i))});
         rd_fifo.push_back(fill_pat(4'(i)));
         if (v.vvalid) evict_q.push_back({4'(i), victim_pat(4'(i))});
      end
      if (v.exp_dv) dout_q.push_back(v.exp_dout);
      cyc = 0;
      @(negedge clock);
      cyc++;
      if (!v.hold) begin
         // Scramble the inputs: the sequencer must work from its latched copy.
         miss         = 1'b0;
         miss_load    = ~v.load;
         miss_addr    = ~v.addr;
         victim_valid = ~v.vvalid;
         victim_tag   = ~v.vtag;
      end
      #1;
      check($sformatf("v%0d_busy_high", idx), 32'(busy), 32'd1);
      check($sformatf("v%0d_readreq", idx), 32'(readreq), 32'd1);
      check($sformatf("v%0d_writereq_early", idx), 32'(writereq), 32'd0);
      check($sformatf("v%0d_rd_addr", idx), 32'(ram_addr), 32'(v.exp_rd));
      req_ready = 1'b1;
      @(negedge clock);
      cyc++;
      req_ready = 1'b0;
      #1;
      check($sformatf("v%0d_readreq_drop", idx), 32'(readreq), 32'd0);
      check($sformatf("v%0d_writereq", idx), 32'(writereq), 32'(v.vvalid));
      if (v.vvalid) begin
         check($sformatf("v%0d_wr_addr", idx), 32'(ram_addr), 32'(v.exp_wr));
         req_ready = 1'b1;
         @(negedge clock);
         cyc++;
         req_ready = 1'b0;
         if (v.stall) begin
            ok = 1'b0;
            for (int k = 0; k < 40 && !ok; k++) begin
               if (victim_waddr == 4'd5) ok = 1'b1;
               else begin
                  @(negedge clock);
                  cyc++;
               end
            end
            check($sformatf("v%0d_stall_reach", idx), 32'(ok), 32'd1);
            writeready = 1'b0;
            for (int k = 0; k < 10; k++) begin
               #1;
               check($sformatf("v%0d_stall_write", idx), 32'(write), 32'd0);
               check($sformatf("v%0d_stall_waddr", idx), 32'(victim_waddr), 32'd5);
               @(negedge clock);
               cyc++;
            end
            writeready = 1'b1;
         end
      end
      ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge clock);
         cyc++;
         #1;
         if (commit) ok = 1'b1;
      end
      check($sformatf("v%0d_commit_seen", idx), 32'(ok), 32'd1);
      miss = 1'b0;
      @(negedge clock);
      cyc++;
      #1;
      check($sformatf("v%0d_busy_low", idx), 32'(busy), 32'd0);
      check($sformatf("v%0d_commit_low", idx), 32'(commit), 32'd0);
      if (idx == 0) check("v0_busy_cycles_ge19", 32'(cyc >= 19), 32'd1);
      @(negedge clock);
      #1;
      check($sformatf("v%0d_busy_stays_low", idx), 32'(busy), 32'd0);
      check($sformatf("v%0d_commit_count", idx), 32'(commit_cnt - c0), 32'd1);
      check($sformatf("v%0d_readreq_count", idx), 32'(readreq_cnt - r0), 32'd1);
      check($sformatf("v%0d_fill_left", idx), 32'(fill_q.size()), 32'd0);
      check($sformatf("v%0d_evict_left", idx), 32'(evict_q.size()), 32'd0);
      check($sformatf("v%0d_dout_left", idx), 32'(dout_q.size()), 32'd0);
   endtask

   // Reset asserted in the middle of a fill: back to idle at once, no commit.
   task automatic run_reset_mid_fill();
      int c0;
      bit ok;
      c0 = commit_cnt;
      @(negedge clock);
      miss         = 1'b1;
      miss_load    = 1'b1;
      miss_addr    = 24'h000050;
      victim_valid = 1'b0;
      victim_tag   = 8'h00;
      rd_toggle    = 1'b0;
      for (int i = 0; i < 16; i++) begin
         fill_q.push_back({4'(i), fill_pat(4'(i))});
         rd_fifo.push_back(fill_pat(4'(i)));
      end
      @(negedge clock);
      miss = 1'b0;
      #1;
      check("rst_readreq", 32'(readreq), 32'd1);
      req_ready = 1'b1;
      @(negedge clock);
      req_ready = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 60 && !ok; k++) begin
         @(negedge clock);
         #1;
         if (fill_we && (fill_waddr == 4'd7)) ok = 1'b1;
      end
      check("rst_reach_word7", 32'(ok), 32'd1);
      reset_n = 1'b0;
      @(negedge clock);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_commit", 32'(commit), 32'd0);
      check("rst_fill_we", 32'(fill_we), 32'd0);
      check("rst_readreq_low", 32'(readreq), 32'd0);
      check("rst_cnt", 32'(fill_waddr), 32'd0);
      reset_n = 1'b1;
      fill_q.delete();
      rd_fifo.delete();
      dout_q.delete();
      pop_pending = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         #1;
         check("rst_idle_after", 32'(busy), 32'd0);
      end
      check("rst_no_commit", 32'(commit_cnt - c0), 32'd0);
   endtask

   initial begin
      //            addr         ld    vv    vtag   tog   stl   hold  exp_rd       exp_wr       dv    dout
      tbl[0] = '{24'h123456, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 24'h123440, 24'h000000, 1'b1, 8'h5B};
      tbl[1] = '{24'h0ABCDE, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 24'h0ABCC0, 24'h0AA240, 1'b1, 8'h5F};
      tbl[2] = '{24'h000001, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 24'h000000, 24'h000000, 1'b1, 8'hB0};
      tbl[3] = '{24'hFFFFFF, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 24'hFFFFE0, 24'hFFE780, 1'b1, 8'hBF};
      tbl[4] = '{24'h7FFFFF, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 24'h7FFFE0, 24'h7FE000, 1'b0, 8'h00};

      repeat (3) @(negedge clock);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_readreq", 32'(readreq), 32'd0);
      check("reset_writereq", 32'(writereq), 32'd0);
      check("reset_ram_addr", 32'(ram_addr), 32'd0);
      check("reset_commit", 32'(commit), 32'd0);
      check("reset_write", 32'(write), 32'd0);
      check("reset_fill_we", 32'(fill_we), 32'd0);
      check("reset_new_dout", 32'(new_dout), 32'd0);
      check("reset_d_out", 32'(d_out), 32'd0);
      check("reset_cnt", 32'(victim_waddr), 32'd0);
      reset_n = 1'b1;
      @(negedge clock);
      #1;
      check("idle_busy", 32'(busy), 32'd0);

      for (int i = 0; i < 5; i++) run_vec(i, tbl[i]);
      run_reset_mid_fill();
      run_vec(5, tbl[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
